sccb_cfg_sequencer: RTL

//  Configures the OV camera after power-up by walking a register table (external ROM) and handing

---
 rtl/sccb_cfg_sequencer.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sccb_cfg_sequencer.sv
// Walks the camera register table and hands each {reg,val} entry to the SCCB write engine,
// with NACK retries, a settle delay after a COM7 soft reset, and an early 16'hFFFF end marker.
module sccb_cfg_sequencer #(
  parameter logic [7:0]  NUM_ENTRIES = 8'd80,
  parameter logic [7:0]  DEV_ADDR    = 8'h42,
  parameter logic [15:0] GAP_CYCLES  = 16'd250,
  parameter logic [19:0] RESET_WAIT  = 20'd25000,
  parameter logic [1:0]  RETRY_MAX   = 2'd3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [7:0]  rom_addr_o,
  input  logic [15:0] rom_data_i,
  output logic        wr_req_o,
  output logic [7:0]  wr_dev_o,
  output logic [7:0]  wr_reg_o,
  output logic [7:0]  wr_val_o,
  input  logic        wr_ack_i,
  input  logic        wr_nack_i,
  output logic        busy_o,
  output logic        work_done_o,
  output logic        error_o,
  output logic [15:0] debug_out_o
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_LATCH  = 4'd2,
    S_ISSUE  = 4'd3,
    S_CHECK  = 4'd4,
    S_GAP    = 4'd5,
    S_SETTLE = 4'd6,
    S_DONE   = 4'd7,
    S_FAIL   = 4'd8
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [1:0]  retry_q, retry_d;
  logic [19:0] cnt_q, cnt_d;
  logic        nack_q, nack_d;
  logic        wr_req_q, wr_req_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  val_q, val_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic [19:0] gap_last_s;
  logic [19:0] settle_last_s;
  logic        last_entry_s;

  assign gap_last_s    = {4'd0, GAP_CYCLES} - 20'd1;
  assign settle_last_s = RESET_WAIT - 20'd1;
  assign last_entry_s  = (addr_q == (NUM_ENTRIES - 8'd1));

  // Next-state logic; outputs are derived from the next state so they register alongside it
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    retry_d  = retry_q;
    cnt_d    = cnt_q;
    nack_d   = nack_q;
    reg_d    = reg_q;
    val_d    = val_q;

    case (state_q)
      S_IDLE, S_DONE, S_FAIL: begin
        if (start_i) begin
          state_d = S_FETCH;
          addr_d  = 8'd0;
          retry_d = 2'd0;
          cnt_d   = 20'd0;
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: state_d = S_LATCH;
      S_LATCH: begin
        if (rom_data_i == 16'hFFFF) begin
          state_d = S_DONE;
        end else begin
          reg_d   = rom_data_i[15:8];
          val_d   = rom_data_i[7:0];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (wr_ack_i) begin
          nack_d  = wr_nack_i;
          state_d = S_CHECK;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_CHECK: begin
        cnt_d = 20'd0;
        if (nack_q) begin
          if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 2'd1;
            state_d = S_GAP;
          end else begin
            state_d = S_FAIL;
          end
        end else begin
          retry_d = 2'd0;
          // COM7 with the soft-reset bit set needs the sensor to settle before the next write
          if (reg_q == 8'h12 && val_q[7]) begin
            state_d = S_SETTLE;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (cnt_q == gap_last_s) begin
          if (retry_q != 2'd0) begin
            state_d = S_ISSUE;
          end else if (last_entry_s) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == settle_last_s) begin
          if (last_entry_s) begin
            state_d = S_DONE;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = S_FETCH;
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    wr_req_d = (state_d == S_ISSUE);
    busy_d   = !((state_d == S_IDLE) || (state_d == S_DONE) || (state_d == S_FAIL));
    done_d   = (state_d == S_DONE);
    err_d    = (state_d == S_FAIL);
  end

  // State and output registers; reset abandons any write in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      addr_q   <= 8'd0;
      retry_q  <= 2'd0;
      cnt_q    <= 20'd0;
      nack_q   <= 1'b0;
      wr_req_q <= 1'b0;
      reg_q    <= 8'd0;
      val_q    <= 8'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      retry_q  <= retry_d;
      cnt_q    <= cnt_d;
      nack_q   <= nack_d;
      wr_req_q <= wr_req_d;
      reg_q    <= reg_d;
      val_q    <= val_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign rom_addr_o  = addr_q;
  assign wr_req_o    = wr_req_q;
  assign wr_dev_o    = DEV_ADDR;
  assign wr_reg_o    = reg_q;
  assign wr_val_o    = val_q;
  assign busy_o      = busy_q;
  assign work_done_o = done_q;
  assign error_o     = err_q;
  assign debug_out_o = {state_q, retry_q, 2'b00, addr_q};

endmodule
